// File: rtl/intra_tu_seq.sv
// intra_tu_seq: sequences one intra transform unit (TU).
// The unit first runs an optional reference-prep phase (PREP), then issues
// every 4x4 block position of the TU (PRED), then gives a one-cycle done
// pulse (DONE).
// Optional feature: define INTRA_SEQ_TRANSPOSE_EN to scan PRED column-major
// when the latched intra mode is 2..17. Without it the scan is always raster.
module intra_tu_seq #(
    parameter int isChroma = 0
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] mode_in,
    input  logic [2:0] tuSize_in,
    input  logic       bStop,
    output logic       busy,
    output logic       valid,
    output logic       last,
    output logic       done,
    output logic       err,
    output logic [2:0] X,
    output logic [2:0] Y,
    output logic [3:0] preStage,
    output logic [5:0] mode,
    output logic [2:0] tuSize
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_PRED = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic [3:0] r_pre, w_pre_nxt;
    logic [5:0] r_mode, w_mode_nxt;
    logic [2:0] r_tusize, w_tusize_nxt;
    logic       r_err, w_err_nxt;

    logic       w_in_legal;
    logic [2:0] w_nmax;
    logic       w_at_last;
    logic       w_col_major;

    // Number of reference-prep stages for a given log2 TU size.
    function automatic logic [3:0] prep_len(input logic [2:0] sz);
        logic [3:0] len;
        len = 4'd0;
        if (isChroma == 0) begin
            case (sz)
                3'd5:    len = 4'd9;
                3'd4:    len = 4'd1;
                default: len = 4'd0;
            endcase
        end
        return len;
    endfunction

    assign w_in_legal = (tuSize_in >= 3'd2) && (tuSize_in <= 3'd5);

    // Highest block index N-1 along each axis, N = 1 << (tuSize-2).
    always_comb begin
        case (r_tusize)
            3'd3:    w_nmax = 3'd1;
            3'd4:    w_nmax = 3'd3;
            3'd5:    w_nmax = 3'd7;
            default: w_nmax = 3'd0;
        endcase
    end

    assign w_at_last = (r_x == w_nmax) && (r_y == w_nmax);

`ifdef INTRA_SEQ_TRANSPOSE_EN
    // Near-horizontal angular modes are walked down columns first.
    assign w_col_major = (r_mode >= 6'd2) && (r_mode <= 6'd17);
`else
    assign w_col_major = 1'b0;
`endif

    // Next-state and next-datapath decode; a stall freezes PREP and PRED.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_pre_nxt    = r_pre;
        w_mode_nxt   = r_mode;
        w_tusize_nxt = r_tusize;
        w_err_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_in_legal) begin
                        w_mode_nxt   = mode_in;
                        w_tusize_nxt = tuSize_in;
                        w_pre_nxt    = 4'd0;
                        w_x_nxt      = 3'd0;
                        w_y_nxt      = 3'd0;
                        w_state_nxt  = (prep_len(tuSize_in) != 4'd0) ? S_PREP : S_PRED;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_PREP: begin
                if (!bStop) begin
                    if (r_pre == prep_len(r_tusize) - 4'd1) begin
                        w_pre_nxt   = 4'd0;
                        w_state_nxt = S_PRED;
                    end else begin
                        w_pre_nxt = r_pre + 4'd1;
                    end
                end
            end
            S_PRED: begin
                if (!bStop) begin
                    if (w_at_last) begin
                        w_x_nxt     = 3'd0;
                        w_y_nxt     = 3'd0;
                        w_state_nxt = S_DONE;
                    end else if (w_col_major) begin
                        if (r_y == w_nmax) begin
                            w_y_nxt = 3'd0;
                            w_x_nxt = r_x + 3'd1;
                        end else begin
                            w_y_nxt = r_y + 3'd1;
                        end
                    end else begin
                        if (r_x == w_nmax) begin
                            w_x_nxt = 3'd0;
                            w_y_nxt = r_y + 3'd1;
                        end else begin
                            w_x_nxt = r_x + 3'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Synchronous clear wins over everything, including a same-cycle start.
        if (!rst_n) begin
            w_state_nxt  = S_IDLE;
            w_x_nxt      = 3'd0;
            w_y_nxt      = 3'd0;
            w_pre_nxt    = 4'd0;
            w_mode_nxt   = 6'd0;
            w_tusize_nxt = 3'd0;
            w_err_nxt    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!arst_n) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Datapath registers: scan position, prep stage, latched TU parameters, err pulse.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_x      <= 3'd0;
            r_y      <= 3'd0;
            r_pre    <= 4'd0;
            r_mode   <= 6'd0;
            r_tusize <= 3'd0;
            r_err    <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_pre    <= w_pre_nxt;
            r_mode   <= w_mode_nxt;
            r_tusize <= w_tusize_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign valid    = (r_state == S_PRED) && !bStop;
    assign last     = (r_state == S_PRED) && w_at_last;
    assign done     = (r_state == S_DONE);
    assign err      = r_err;
    assign X        = (r_state == S_PRED) ? r_x : 3'd0;
    assign Y        = (r_state == S_PRED) ? r_y : 3'd0;
    assign preStage = (r_state == S_PREP) ? r_pre :
                      (r_state == S_PRED) ? 4'hF : 4'd0;
    assign mode     = r_mode;
    assign tuSize   = r_tusize;

endmodule

// File: tb/tb_intra_tu_seq.sv
// Self-checking bench for intra_tu_seq: a scoreboard queue of expected
// output events (prep stage, block position, done, err), each tagged with
// the cycle it must appear in, plus direct cycle-level checks.
module tb_intra_tu_seq;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [5:0] mode_in = 6'd0;
    logic [2:0] tuSize_in = 3'd0;
    logic       bStop = 1'b0;
    logic       busy, valid, last, done, err;
    logic [2:0] X, Y;
    logic [3:0] preStage;
    logic [5:0] mode;
    logic [2:0] tuSize;

    intra_tu_seq dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .rst_n    (rst_n),
        .start    (start),
        .mode_in  (mode_in),
        .tuSize_in(tuSize_in),
        .bStop    (bStop),
        .busy     (busy),
        .valid    (valid),
        .last     (last),
        .done     (done),
        .err      (err),
        .X        (X),
        .Y        (Y),
        .preStage (preStage),
        .mode     (mode),
        .tuSize   (tuSize)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum logic [1:0] {K_POS = 2'd0, K_PRE = 2'd1, K_DONE = 2'd2, K_ERR = 2'd3} kind_t;
    typedef struct packed {
        kind_t       kind;
        logic [15:0] cyc;
        logic [2:0]  x;
        logic [2:0]  y;
        logic        last;
        logic [3:0]  pre;
    } ev_t;

    ev_t sb_q[$];

    function automatic string ev_str(ev_t e);
        return $sformatf("kind=%0d cyc=%0d x=%0d y=%0d last=%0d pre=%h",
                         e.kind, e.cyc, e.x, e.y, e.last, e.pre);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(kind_t k, int c, int x, int y, bit l, int p);
        ev_t e;
        e.kind = k;
        e.cyc  = 16'(c);
        e.x    = 3'(x);
        e.y    = 3'(y);
        e.last = l;
        e.pre  = 4'(p);
        sb_q.push_back(e);
    endtask

    // Expected events of one TU started in cycle c0. The block at scan index
    // stall_idx is delayed by stall_len cycles. Only the first npos positions
    // are pushed; done is pushed only when the whole TU is.
    task automatic push_tu(int c0, int sz, int md, int stall_idx, int stall_len, int npos);
        int  plen;
        int  n;
        int  c;
        bit  col;
        col  = 1'b0;
`ifdef INTRA_SEQ_TRANSPOSE_EN
        col  = (md >= 2) && (md <= 17);
`endif
        plen = (sz == 5) ? 9 : (sz == 4) ? 1 : 0;
        n    = 1 << (sz - 2);
        for (int p = 0; p < plen; p++) push(K_PRE, c0 + 1 + p, 0, 0, 1'b0, p);
        c = c0 + 1 + plen;
        for (int i = 0; i < n * n && i < npos; i++) begin
            if (i == stall_idx) c += stall_len;
            if (col) push(K_POS, c, i / n, i % n, i == n * n - 1, 15);
            else     push(K_POS, c, i % n, i / n, i == n * n - 1, 15);
            c++;
        end
        if (npos >= n * n) push(K_DONE, c, 0, 0, 1'b0, 0);
    endtask

    // Monitor: turns whatever the DUT presents this cycle into an event and
    // compares it with the head of the scoreboard.
    always @(negedge clk) begin
        ev_t ob;
        ev_t ex;
        bit  seen;
        seen    = 1'b1;
        ob.cyc  = 16'(cyc);
        ob.x    = X;
        ob.y    = Y;
        ob.last = last;
        ob.pre  = preStage;
        if (valid)                          ob.kind = K_POS;
        else if (done)                      ob.kind = K_DONE;
        else if (err)                       ob.kind = K_ERR;
        else if (busy && preStage != 4'hF)  ob.kind = K_PRE;
        else begin
            ob.kind = K_POS;
            seen    = 1'b0;
        end
        if (seen) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected actual: %s expected: none", ev_str(ob));
            end else begin
                ex = sb_q.pop_front();
                if (ob !== ex) begin
                    n_errors++;
                    $display("FAIL sb_event actual: %s expected: %s", ev_str(ob), ev_str(ex));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(int sz, int md, output int c0);
        start     = 1'b1;
        tuSize_in = 3'(sz);
        mode_in   = 6'(md);
        c0        = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(int max_cycles);
        int k;
        k = 0;
        while (busy && k < max_cycles) begin
            tick();
            k++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int ex_x[4];
        int ex_y[4];

        // Asynchronous reset state, before any clock edge.
        #2;
        check("rst_busy_valid_done_err", {busy, valid, done, err}, 4'b0000);
        check("rst_xy_pre", {X, Y, preStage}, 10'd0);
        check("rst_mode_tusize", {mode, tuSize}, 9'd0);
        tick();
        tick();
        arst_n = 1'b1;
        tick();

        // Smallest TU: one block, done next cycle.
        launch(2, 26, c0);
        push_tu(c0, 2, 26, -1, 0, 999);
        check("t2_valid", valid, 1'b1);
        check("t2_xy", {X, Y}, 6'd0);
        check("t2_last", last, 1'b1);
        check("t2_latched", {mode, tuSize}, {6'd26, 3'd2});
        tick();
        check("t2_done", done, 1'b1);
        tick();
        check("t2_idle", busy, 1'b0);
        tick();

        // Largest TU: 9 prep stages, 64 positions, done at cycle 74.
        launch(5, 1, c0);
        push_tu(c0, 5, 1, -1, 0, 999);
        check("t5_prep0", preStage, 4'd0);
        wait_idle(200);
        check("t5_latency", cyc - c0, 75);
        tick();

        // tuSize 3 scan order (hand table) plus an ignored start while busy.
`ifdef INTRA_SEQ_TRANSPOSE_EN
        ex_x = '{0, 0, 1, 1};
        ex_y = '{0, 1, 0, 1};
`else
        ex_x = '{0, 1, 0, 1};
        ex_y = '{0, 0, 1, 1};
`endif
        launch(3, 10, c0);
        for (int i = 0; i < 4; i++) push(K_POS, c0 + 1 + i, ex_x[i], ex_y[i], i == 3, 15);
        push(K_DONE, c0 + 5, 0, 0, 1'b0, 0);
        tick();
        start     = 1'b1;
        mode_in   = 6'd40;
        tuSize_in = 3'd2;
        tick();
        start     = 1'b0;
        wait_idle(20);
        check("busy_start_mode", mode, 6'd10);
        check("busy_start_tusize", tuSize, 3'd3);
        tick();

        // Illegal size: one-cycle err, stays idle, latched values kept.
        launch(6, 50, c0);
        push(K_ERR, c0 + 1, 0, 0, 1'b0, 0);
        check("err_pulse", err, 1'b1);
        check("err_busy", busy, 1'b0);
        tick();
        check("err_clear", err, 1'b0);
        check("err_still_idle", busy, 1'b0);
        check("err_mode_kept", {mode, tuSize}, {6'd10, 3'd3});
        tick();

        // Stall of 3 cycles at (2,1) in a tuSize 4 TU.
        launch(4, 26, c0);
        push_tu(c0, 4, 26, 6, 3, 999);
        repeat (7) tick();
        bStop = 1'b1;
        #1;
        check("stall_xy_0", {X, Y}, {3'd2, 3'd1});
        check("stall_valid_0", valid, 1'b0);
        for (int s = 1; s < 3; s++) begin
            tick();
            check("stall_xy", {X, Y}, {3'd2, 3'd1});
            check("stall_valid", valid, 1'b0);
        end
        tick();
        bStop = 1'b0;
        #1;
        check("stall_resume_xy", {X, Y}, {3'd2, 3'd1});
        check("stall_resume_valid", valid, 1'b1);
        tick();
        check("stall_next_xy", {X, Y}, {3'd3, 3'd1});
        wait_idle(40);
        tick();

        // Synchronous clear mid-PRED, then clear and start in the same cycle.
        launch(3, 26, c0);
        push_tu(c0, 3, 26, -1, 0, 2);
        tick();
        rst_n = 1'b0;
        tick();
        check("srst_busy", busy, 1'b0);
        check("srst_latched", {mode, tuSize}, 9'd0);
        start     = 1'b1;
        mode_in   = 6'd7;
        tuSize_in = 3'd2;
        tick();
        start = 1'b0;
        rst_n = 1'b1;
        check("srst_prio_busy", busy, 1'b0);
        check("srst_prio_mode", mode, 6'd0);
        repeat (5) tick();

        // Asynchronous reset mid-PRED of a tuSize 5 TU.
        launch(5, 1, c0);
        push_tu(c0, 5, 1, -1, 0, 6);
        repeat (14) tick();
        #5;
        arst_n = 1'b0;
        #1;
        check("arst_busy_valid", {busy, valid}, 2'b00);
        check("arst_xy_pre", {X, Y, preStage}, 10'd0);
        check("arst_latched", {mode, tuSize}, 9'd0);
        repeat (3) tick();
        arst_n = 1'b1;
        repeat (80) tick();

        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
